// File: rtl/sram_ctrl.sv
// Single-port SRAM with valid/ready requests, byte enables, a READ_LATENCY-deep
// read pipeline and a zero-fill sweep of the whole array after every reset.
module sram_ctrl #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_be,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  init_done
);

   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);

   typedef enum logic {CLEAR, RUN} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W:0]     ptr_q, ptr_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [READ_LATENCY-1:0] vld_q;
   logic [DATA_W-1:0]   data_q [READ_LATENCY];
   logic                clr_we, rd_hs, wr_hs;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == CLEAR) begin
         ptr_d = ptr_q + 1'b1;
         if (ptr_q == LAST_PTR) state_d = RUN;
      end
   end

   // Outputs are forced to their reset values while rst is high, not just after it.
   always_comb begin
      req_ready = 1'b0;
      init_done = 1'b0;
      clr_we    = 1'b0;
      if (!rst) begin
         if (state_q == RUN) begin
            req_ready = 1'b1;
            init_done = 1'b1;
         end else begin
            clr_we = 1'b1;
         end
      end
   end

   assign rd_hs = req_valid & req_ready & ~req_we;
   assign wr_hs = req_valid & req_ready &  req_we;

   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem_q[ptr_q[ADDR_W-1:0]] <= '0;
      end else if (wr_hs) begin
         for (int b = 0; b < NB; b++)
            if (req_be[b]) mem_q[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
      end
   end

   // Data stages only load when a valid word moves in, so the last stage holds between pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         for (int s = 0; s < READ_LATENCY; s++) data_q[s] <= '0;
      end else begin
         vld_q[0] <= rd_hs;
         if (rd_hs) data_q[0] <= mem_q[req_addr];
         for (int s = 1; s < READ_LATENCY; s++) begin
            vld_q[s] <= vld_q[s-1];
            if (vld_q[s-1]) data_q[s] <= data_q[s-1];
         end
      end
   end

   assign rsp_valid = vld_q[READ_LATENCY-1] & ~rst;
   assign rsp_rdata = rst ? '0 : data_q[READ_LATENCY-1];

endmodule
